sar_adc_ctrl: RTL

// - Successive-approximation ADC controller: the input-side counterpart of the parallel R-2R DAC output.
// - Drives an external R-2R ladder through dac_out, reads back an external analog comparator on cmp_in,
//   and binary-searches the sampled input voltage into a WIDTH-bit code.
// - Controls an external sample/hold and delivers each result over a valid/ready handshake to the consumer.

---
 rtl/sar_adc_pkg.sv | 32 +++
 rtl/sar_adc_if.sv | 31 +++
 rtl/sar_adc_cmp_sync.sv | 28 ++
 rtl/sar_adc_ctrl.sv | 135 +++++++++++++
 4 files changed

// File: rtl/sar_adc_pkg.sv
// Shared types and timing helpers for the successive-approximation ADC controller.
// Conversion timing is derived here so the controller and any wrapper agree on it.
package sar_adc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_TRIAL  = 2'd2
  } state_e;

  localparam int unsigned DEF_WIDTH         = 8;
  localparam int unsigned DEF_SETTLE_CYCLES = 4;
  localparam int unsigned DEF_SAMPLE_CYCLES = 8;

  // One bit trial: drive cycle, settle wait, two synchronizer stages.
  function automatic int unsigned bit_cycles(input int unsigned settle_cycles);
    return settle_cycles + 3;
  endfunction

  function automatic int unsigned conv_cycles(input int unsigned width,
                                              input int unsigned settle_cycles,
                                              input int unsigned sample_cycles);
    return sample_cycles + width * bit_cycles(settle_cycles);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned BIT_CYCLES = bit_cycles(DEF_SETTLE_CYCLES);

endpackage

// File: rtl/sar_adc_if.sv
// Request/result handshake between the ADC controller (master) and its consumer (slave).
interface sar_adc_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic             start;
  logic             busy;
  logic [WIDTH-1:0] result;
  logic             result_valid;
  logic             result_ready;
  logic             overrun;

  modport master (
    input  start,
    input  result_ready,
    output busy,
    output result,
    output result_valid,
    output overrun
  );

  modport slave (
    output start,
    output result_ready,
    input  busy,
    input  result,
    input  result_valid,
    input  overrun
  );

endinterface

// File: rtl/sar_adc_cmp_sync.sv
// Two-flop synchronizer for asynchronous inputs, one independent chain per bit.
module cmp_sync #(
  parameter int unsigned N = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] async_i,
  output logic [N-1:0] sync_o
);

  for (genvar gi = 0; gi < N; gi++) begin : g_bit
    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        meta_q <= 1'b0;
        sync_q <= 1'b0;
      end else begin
        meta_q <= async_i[gi];
        sync_q <= meta_q;
      end
    end

    assign sync_o[gi] = sync_q;
  end

endmodule

// File: rtl/sar_adc_ctrl.sv
// SAR ADC controller: samples via external S/H, binary-searches the input against an R-2R
// ladder and comparator, and hands each code to the consumer over valid/ready.
module sar_adc_ctrl
  import sar_adc_pkg::*;
#(
  parameter int unsigned WIDTH         = DEF_WIDTH,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int unsigned SAMPLE_CYCLES = DEF_SAMPLE_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  sar_adc_if.master        bus,
  output logic             sample_hold_o,
  output logic [WIDTH-1:0] dac_out_o,
  input  logic             cmp_in_i
);

  localparam int unsigned BIT_CYC  = bit_cycles(SETTLE_CYCLES);
  localparam int unsigned MAX_LOAD = max_u(SAMPLE_CYCLES, BIT_CYC) - 1;
  localparam int unsigned CNT_W    = $clog2(MAX_LOAD + 1);

  localparam logic [CNT_W-1:0] SAMPLE_LOAD = CNT_W'(SAMPLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] BIT_LOAD    = CNT_W'(BIT_CYC - 1);
  localparam logic [WIDTH-1:0] MSB_SEL     = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] bit_sel_q;
  logic [WIDTH-1:0] code_q;
  logic [WIDTH-1:0] dac_q;
  logic             sh_q;
  logic             busy_q;
  logic [WIDTH-1:0] result_q;
  logic             valid_q;
  logic             overrun_q;

  logic             cmp_s;
  logic [WIDTH-1:0] code_d;
  logic [WIDTH-1:0] trial_d;

  cmp_sync #(
    .N(1)
  ) u_cmp_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (cmp_in_i),
    .sync_o  (cmp_s)
  );

  // dac_q already carries the bit under test, so keeping it is just taking dac_q.
  assign code_d  = cmp_s ? dac_q : code_q;
  assign trial_d = code_d | (bit_sel_q >> 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_sel_q <= '0;
      code_q    <= '0;
      dac_q     <= '0;
      sh_q      <= 1'b0;
      busy_q    <= 1'b0;
      result_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (valid_q && bus.result_ready) begin
        valid_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          dac_q <= '0;
          sh_q  <= 1'b0;
          if (bus.start) begin
            state_q <= ST_SAMPLE;
            cnt_q   <= SAMPLE_LOAD;
            busy_q  <= 1'b1;
            sh_q    <= 1'b1;
          end
        end

        ST_SAMPLE: begin
          if (cnt_q == '0) begin
            state_q   <= ST_TRIAL;
            cnt_q     <= BIT_LOAD;
            sh_q      <= 1'b0;
            bit_sel_q <= MSB_SEL;
            code_q    <= '0;
            dac_q     <= MSB_SEL;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        ST_TRIAL: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (bit_sel_q[0]) begin
            // Last bit decided: publish, even over an unconsumed result.
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            dac_q     <= '0;
            code_q    <= code_d;
            bit_sel_q <= '0;
            result_q  <= code_d;
            valid_q   <= 1'b1;
            overrun_q <= valid_q && !bus.result_ready;
          end else begin
            cnt_q     <= BIT_LOAD;
            code_q    <= code_d;
            bit_sel_q <= bit_sel_q >> 1;
            dac_q     <= trial_d;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          sh_q    <= 1'b0;
          dac_q   <= '0;
        end
      endcase
    end
  end

  assign bus.busy         = busy_q;
  assign bus.result       = result_q;
  assign bus.result_valid = valid_q;
  assign bus.overrun      = overrun_q;
  assign sample_hold_o    = sh_q;
  assign dac_out_o        = dac_q;

endmodule
